// File: rtl/sid_pkg.sv
// Shared constants and helpers for the SID potentiometer ADC.
//
// The pot converter runs a 512-cycle period. For the first 256 cycles the
// pins are dumped to ground (DUMP). For the last 256 cycles the capacitors
// charge (CHARGE), and the cycle index of the first comparator crossing
// becomes the 8-bit reading.
package sid_pkg;

    localparam int          POT_PERIOD      = 512;
    localparam int          POT_DUMP_CYCLES = 256;
    localparam logic [7:0]  POT_NOTRIP      = 8'hFF;

    localparam int          CNT_W           = 9;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POT_PERIOD - 1);

    typedef enum logic {
        PH_DUMP   = 1'b0,
        PH_CHARGE = 1'b1
    } pot_phase_e;

    // Phase decode of the period counter.
    function automatic pot_phase_e phase_of(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(POT_DUMP_CYCLES)) ? PH_CHARGE : PH_DUMP;
    endfunction

endpackage

// File: rtl/sid_pot_channel.sv
// One potentiometer channel: comparator synchronizer, first-crossing
// capture and the output latch that publishes a reading once per period.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   phi2_en_i  one-clk strobe per SID cycle
//   cnt_i      shared 9-bit period counter (value before this strobe)
//   comp_i     raw comparator input, asynchronous to clk_i
//   pot_o      last completed conversion
module sid_pot_channel
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             phi2_en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             comp_i,
    output logic [7:0]       pot_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tripped_q, tripped_d;
    logic [7:0]             cap_q, cap_d;
    logic [7:0]             pot_q, pot_d;
    logic                   comp_s;

    assign comp_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], comp_i};
        tripped_d = tripped_q;
        cap_d     = cap_q;
        pot_d     = pot_q;
        if (phi2_en_i) begin
            // Only the first crossing in CHARGE counts; DUMP activity is ignored.
            if ((phase_of(cnt_i) == PH_CHARGE) && !tripped_q && comp_s) begin
                cap_d     = cnt_i[7:0];
                tripped_d = 1'b1;
            end
            // End of period: publish and re-arm. A crossing on this very
            // strobe reads 8'hFF, which coincides with the no-trip value.
            if (cnt_i == CNT_LAST) begin
                pot_d     = tripped_q ? cap_q : POT_NOTRIP;
                tripped_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            tripped_q <= 1'b0;
            cap_q     <= 8'h00;
            pot_q     <= 8'h00;
        end else begin
            sync_q    <= sync_d;
            tripped_q <= tripped_d;
            cap_q     <= cap_d;
            pot_q     <= pot_d;
        end
    end

    assign pot_o = pot_q;

endmodule

// File: rtl/sid_pot_adc.sv
// SID POTX/POTY converter top: shared 512-cycle phase counter, the
// registered dump control and two independent channel instances.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   phi2_en    one-clk strobe per SID cycle
//   comp_x/y   pot pin comparators (1 = above threshold), asynchronous
//   pot_dump   1 = discharge transistors on (DUMP phase)
//   pot_x/y    last completed conversions
//   pot_valid  one-clk pulse when pot_x/pot_y update
module sid_pot_adc
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phi2_en,
    input  logic       comp_x,
    input  logic       comp_y,
    output logic       pot_dump,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic       pot_valid
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pot_dump_q, pot_dump_d;
    logic             pot_valid_q, pot_valid_d;

    always_comb begin
        cnt_d       = cnt_q;
        pot_valid_d = 1'b0;
        if (phi2_en) begin
            cnt_d       = cnt_q + CNT_W'(1);   // wraps 511 -> 0
            pot_valid_d = (cnt_q == CNT_LAST);
        end
        // Registered from the next count so the dump pin tracks the phase
        // of the counter value it is presented with.
        pot_dump_d = (phase_of(cnt_d) == PH_DUMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pot_dump_q  <= 1'b1;
            pot_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pot_dump_q  <= pot_dump_d;
            pot_valid_q <= pot_valid_d;
        end
    end

    sid_pot_channel #(.SYNC_STAGES(SYNC_STAGES)) u_chan_x (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .phi2_en_i (phi2_en),
        .cnt_i     (cnt_q),
        .comp_i    (comp_x),
        .pot_o     (pot_x)
    );

    sid_pot_channel #(.SYNC_STAGES(SYNC_STAGES)) u_chan_y (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .phi2_en_i (phi2_en),
        .cnt_i     (cnt_q),
        .comp_i    (comp_y),
        .pot_o     (pot_y)
    );

    assign pot_dump  = pot_dump_q;
    assign pot_valid = pot_valid_q;

endmodule

// File: tb/tb_sid_pot_adc.sv
// Bench for sid_pot_adc. phi2_en strobes every 4 clk. Comparator levels are
// changed just after the strobe preceding the one at which they must be
// seen, so the synchronized value is settled by the target strobe.
module tb_sid_pot_adc;
    import sid_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       phi2_en = 1'b0;
    logic       comp_x = 1'b0;
    logic       comp_y = 1'b0;
    logic       pot_dump;
    logic [7:0] pot_x;
    logic [7:0] pot_y;
    logic       pot_valid;

    sid_pot_adc #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phi2_en   (phi2_en),
        .comp_x    (comp_x),
        .comp_y    (comp_y),
        .pot_dump  (pot_dump),
        .pot_x     (pot_x),
        .pot_y     (pot_y),
        .pot_valid (pot_valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded 1 ms");
        $fatal(1, "timeout");
    end

    // ---------------- bench state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_x_q[$];
    logic [7:0] exp_y_q[$];
    logic [7:0] last_x = 8'h00;
    logic [7:0] last_y = 8'h00;
    int cur_k = -1;
    // comparator schedule: rise / fall / second rise strobe index, -1 = never
    int xr = -1, xf = -1, xr2 = -1, yr = -1, yf = -1;

    function automatic logic wave(int k, int r, int f, int r2);
        return ((r >= 0) && (k >= r) && ((f < 0) || (k < f))) ||
               ((r2 >= 0) && (k >= r2));
    endfunction

    function automatic logic [7:0] expect_cap(int r, int f, int r2);
        for (int k = 256; k < 512; k++)
            if (wave(k, r, f, r2)) return 8'(k - 256);
        return 8'hFF;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [7:0] ex, ey;
        #1;
        if (pot_valid === 1'b1) begin
            tests_run++;
            if (cur_k != 511) begin
                tests_failed++;
                $display("FAIL valid_timing: pot_valid at strobe %0d, required 511", cur_k);
            end
            if (exp_x_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_valid: pot_valid=1 with no conversion pending");
            end else begin
                ex = exp_x_q.pop_front();
                ey = exp_y_q.pop_front();
                tests_run++;
                if (pot_x !== ex) begin
                    tests_failed++;
                    $display("FAIL pot_x: got %02h, required %02h", pot_x, ex);
                end
                tests_run++;
                if (pot_y !== ey) begin
                    tests_failed++;
                    $display("FAIL pot_y: got %02h, required %02h", pot_y, ey);
                end
                last_x = ex;
                last_y = ey;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int k);
        @(negedge clk);
        phi2_en = 1'b0;
        comp_x  = wave(k, xr, xf, xr2);
        comp_y  = wave(k, yr, yf, -1);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (pot_dump !== (k < 256)) begin
            tests_failed++;
            $display("FAIL pot_dump: cnt=%0d got %b, required %b", k, pot_dump, (k < 256));
        end
        if (k == 100) begin
            tests_run++;
            if (pot_x !== last_x || pot_y !== last_y) begin
                tests_failed++;
                $display("FAIL hold: pot_x/y %02h/%02h, required %02h/%02h",
                         pot_x, pot_y, last_x, last_y);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cur_k   = k;
        phi2_en = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_period(input int n);
        for (int k = 0; k < n; k++) step(k);
        @(negedge clk);
        phi2_en = 1'b0;
        cur_k   = -1;
        if (n == 512) begin
            tests_run++;
            if (exp_x_q.size() != 0) begin
                tests_failed++;
                $display("FAIL missing_valid: %0d conversions still pending, required 0",
                         exp_x_q.size());
                exp_x_q.delete();
                exp_y_q.delete();
            end
        end
    endtask

    task automatic sched(input int a, input int b, input int c, input int d, input int e);
        xr = a; xf = b; xr2 = c; yr = d; yf = e;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (pot_x !== 8'h00 || pot_y !== 8'h00 || pot_valid !== 1'b0 || pot_dump !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: x=%02h y=%02h v=%b d=%b, required 00 00 0 1",
                     pot_x, pot_y, pot_valid, pot_dump);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_no_trip();
        sched(-1, -1, -1, -1, -1);
        exp_x_q.push_back(8'hFF); exp_y_q.push_back(8'hFF);
        run_period(512);
    endtask

    task automatic test_two_crossings();
        sched(356, -1, -1, 300, -1);
        exp_x_q.push_back(8'd100); exp_y_q.push_back(8'd44);
        run_period(512);
    endtask

    task automatic test_dump_ignore();
        sched(0, -1, -1, -1, -1);
        exp_x_q.push_back(8'h00); exp_y_q.push_back(8'hFF);
        run_period(512);
    endtask

    task automatic test_first_only();
        sched(320, 330, 400, -1, -1);
        exp_x_q.push_back(8'd64); exp_y_q.push_back(8'hFF);
        run_period(512);
    endtask

    task automatic test_edge_511();
        sched(-1, -1, -1, 511, -1);
        exp_x_q.push_back(8'hFF); exp_y_q.push_back(8'hFF);
        run_period(512);
        sched(-1, -1, -1, 260, -1);
        exp_x_q.push_back(8'hFF); exp_y_q.push_back(8'd4);
        run_period(512);
    endtask

    task automatic test_reset_mid();
        sched(-1, -1, -1, 300, -1);
        run_period(400);
        @(negedge clk);
        rst_n  = 1'b0;
        comp_x = 1'b0;
        comp_y = 1'b0;
        sched(-1, -1, -1, -1, -1);
        #1;
        tests_run++;
        if (pot_x !== 8'h00 || pot_y !== 8'h00 || pot_valid !== 1'b0 || pot_dump !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: x=%02h y=%02h v=%b d=%b, required 00 00 0 1",
                     pot_x, pot_y, pot_valid, pot_dump);
        end
        last_x = 8'h00;
        last_y = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_x_q.push_back(8'hFF); exp_y_q.push_back(8'hFF);
        run_period(512);
    endtask

    task automatic test_back_to_back();
        int a, d;
        for (int p = 0; p < 4; p++) begin
            a = int'($urandom_range(0, 520)) - 8;
            d = (p == 1) ? a : int'($urandom_range(0, 520)) - 8;
            if (a < 0) a = -1;
            if (d < 0) d = -1;
            sched(a, -1, -1, d, -1);
            exp_x_q.push_back(expect_cap(a, -1, -1));
            exp_y_q.push_back(expect_cap(d, -1, -1));
            run_period(512);
        end
    endtask

    initial begin
        test_reset();
        test_no_trip();
        test_two_crossings();
        test_dump_ignore();
        test_first_only();
        test_edge_511();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
